hazard_unit: RTL and testbench
==============================

# hazard_unit

Parametrised pipeline hazard unit for the MIPS core. It sits beside the decode-stage controller and tracks every in-flight register destination in the E/M/W stages. Each cycle it compares the decode-stage instruction's source registers against those destinations. From that it produces the decode stall and per-operand forwarding selects, and it runs a busy counter for the multi-cycle multiply/divide unit.

## Interface
- `REG_W`, 5: register address width.
- `STAGES`, 3: tracked stages after D (1=E, 2=M, 3=W).
- `T_W`, 2: width of Tnew/Tuse fields; all-ones Tuse = operand not read.
- `MUL_LAT`, 5: multiply busy cycles.
- `DIV_LAT`, 10: divide busy cycles.
- `clk  in  1  clock`
- `reset  in  1  reset, synchronous, active-low`
- `d_valid  in  1  decode slot holds a real instruction (0 = bubble)`
- `d_rs, d_rt  in  REG_W  source registers`
- `d_rs_tuse, d_rt_tuse  in  T_W  cycles until operand needed`
- `d_dst  in  REG_W  destination (0 = none)`
- `d_tnew  in  T_W  cycles after entering E until result exists`
- `d_md_start  in  1  instruction starts mult/div`
- `d_md_div  in  1  started op is a divide`
- `d_md_use  in  1  instruction reads/writes HI/LO or starts mult/div`
- `stall  out  1  hold F/D, insert bubble into E`
- `fwd_rs, fwd_rt  out  $clog2(STAGES+1)  0 = register file, k = stage k`
- `md_busy  out  1  mult/div counter nonzero`

## Operation
- Per stage k, the unit holds a record `{valid, dst, tnew}`. Reset sets all records to invalid, the counter to 0, and `stall`/`fwd_*`/`md_busy` to 0.
- Each clock:
  - Record k moves to k+1 with `tnew` decremented, saturating at 0.
  - Record STAGES drops out.
  - Stage 1 loads `{d_valid & ~stall, d_dst, d_tnew}`. A stall therefore inserts an invalid record.
- Match for operand r (rs or rt): the lowest k with `valid` set, `dst == r` and `r != 0`. Only the nearest match counts; older stages are ignored.
- Operand stall: a match exists, Tuse ≠ all-ones, and the match's `tnew > tuse`.
- Forward select for an operand:
  - k if a match exists with `tnew == 0`.
  - 0 otherwise, including when the match has `0 < tnew ≤ tuse`. A later stage forwards in that case.
- md stall: `d_md_use & md_busy`.
- `stall = d_valid & (rs_stall | rt_stall | md_stall)`.
- `fwd_*` is still driven while stalling. With `d_valid = 0`, `fwd_*` = 0.
- Counter behaviour:
  - If `d_valid & d_md_start & ~stall`, it loads `DIV_LAT` if `d_md_div`, else `MUL_LAT`.
  - Otherwise it decrements when nonzero.
  - `md_busy` = counter ≠ 0.

## Timing
- `stall`, `fwd_rs`, `fwd_rt` and `md_busy` are combinational from the registered state and the current D inputs, in the same cycle. No internal latency.
- Records update on the rising edge. The counter updates on the same edge and is visible from the next cycle.
- Reset asserted mid-operation clears every record and the counter at that edge; the next cycle shows no stall.
- Simultaneous load and decrement cannot happen, because load requires the counter to be 0 (a `md_use` instruction stalls while busy).
- Register 0 never matches, never stalls and never forwards.

## Structure
- Shared package `hazard_pkg`:
  - `TUSE_NONE` constant.
  - Stage-index localparams `STG_E/M/W`.
  - Record struct `{valid, dst, tnew}`.
- One sub-module, `hazard_match`, instantiated per operand: priority search over records, returns `{hit, k, tnew}`.
- Records are a parametrised shift array of length `STAGES`.

## Test plan
- Reset: hold `reset = 0` for 2 cycles with random inputs → all outputs 0. Release, `d_valid = 1`, `d_rs = 8` → `stall = 0`, `fwd_rs = 0`.
- Load-use: `lw $8` (tnew 2) enters E; next D is `addu $9,$8,$8` (tuse 1) → `stall = 1` for 1 cycle. Next cycle `stall = 0`, `fwd_rs = 0` (M, tnew 1).
- Branch after ALU op: `addiu $8` (tnew 1) in E; D is `beq $8,$0` (tuse 0) → 1 stall. Then `fwd_rs = 2`.
- Nearest wins: `$8` in stage 1 with tnew 1 and in stage 2 with tnew 0; D reads `$8` with tuse 1 → `stall = 0`, `fwd_rs = 0`, not 2.
- $0 and Tuse=none: stage 1 has dst 0; D reads `$0`, and `$8` with Tuse all-ones while `$8` pending with tnew 2 → no stall, fwd 0.
- Mult/div: issue `div` → `md_busy` high for exactly `DIV_LAT` cycles. `mflo` in D during that time → `stall` until the first cycle with `md_busy = 0`. `mult` with `MUL_LAT = 5` → 5 busy cycles.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types and constants for the decode-stage hazard unit.
// Records are sized by HZ_REG_W/HZ_T_W; the unit's REG_W/T_W must match them.
package hazard_pkg;

  localparam int HZ_REG_W = 5;
  localparam int HZ_T_W   = 2;

  localparam int STG_E = 1;
  localparam int STG_M = 2;
  localparam int STG_W = 3;

  localparam logic [HZ_T_W-1:0] TUSE_NONE = '1;

  typedef struct packed {
    logic              valid;
    logic [HZ_REG_W-1:0] dst;
    logic [HZ_T_W-1:0]   tnew;
  } hz_rec_t;

  function automatic logic [HZ_T_W-1:0] tnew_dec(input logic [HZ_T_W-1:0] t);
    return (t == '0) ? '0 : t - HZ_T_W'(1);
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Decode-stage request bundle and hazard responses between controller and hazard unit.
interface hazard_unit_if #(
  parameter int REG_W = 5,
  parameter int T_W   = 2,
  parameter int FWD_W = 2
);
  logic             d_valid;
  logic [REG_W-1:0] d_rs;
  logic [REG_W-1:0] d_rt;
  logic [T_W-1:0]   d_rs_tuse;
  logic [T_W-1:0]   d_rt_tuse;
  logic [REG_W-1:0] d_dst;
  logic [T_W-1:0]   d_tnew;
  logic             d_md_start;
  logic             d_md_div;
  logic             d_md_use;
  logic             stall;
  logic [FWD_W-1:0] fwd_rs;
  logic [FWD_W-1:0] fwd_rt;
  logic             md_busy;

  modport master (
    output d_valid, d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_dst, d_tnew,
           d_md_start, d_md_div, d_md_use,
    input  stall, fwd_rs, fwd_rt, md_busy
  );

  modport slave (
    input  d_valid, d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_dst, d_tnew,
           d_md_start, d_md_div, d_md_use,
    output stall, fwd_rs, fwd_rt, md_busy
  );
endinterface

// File: rtl/hazard_match.sv
// Priority search for the nearest in-flight record writing a given source register.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int STAGES = 3,
  parameter int REG_W  = HZ_REG_W,
  parameter int T_W    = HZ_T_W,
  parameter int K_W    = $clog2(STAGES + 1)
) (
  input  hz_rec_t          recs [1:STAGES],
  input  logic [REG_W-1:0] r,
  output logic             hit,
  output logic [K_W-1:0]   k,
  output logic [T_W-1:0]   tnew
);

  logic [STAGES:1] stage_hit;

  genvar gi;
  generate
    for (gi = 1; gi <= STAGES; gi++) begin : g_cmp
      assign stage_hit[gi] = recs[gi].valid && (recs[gi].dst == r) && (r != '0);
    end
  endgenerate

  // Walk oldest to youngest so the youngest (lowest k) hit is the one kept.
  always_comb begin
    hit  = 1'b0;
    k    = '0;
    tnew = '0;
    for (int i = STAGES; i >= 1; i--) begin
      if (stage_hit[i]) begin
        hit  = 1'b1;
        k    = K_W'(i);
        tnew = recs[i].tnew;
      end
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: tracks E/M/W destinations, drives decode stall, forward selects
// and the mult/div busy counter.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_W   = HZ_REG_W,
  parameter int STAGES  = 3,
  parameter int T_W     = HZ_T_W,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input logic           clk,
  input logic           reset,
  hazard_unit_if.slave  hz
);

  localparam int FWD_W = $clog2(STAGES + 1);
  localparam int CNT_W = $clog2(((DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT) + 1);

  hz_rec_t          rec_q [1:STAGES];
  hz_rec_t          rec_d [1:STAGES];
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic             rs_hit, rt_hit;
  logic [FWD_W-1:0] rs_k, rt_k;
  logic [T_W-1:0]   rs_tnew, rt_tnew;
  logic             rs_stall, rt_stall, md_stall, stall_c;

  hazard_match #(.STAGES(STAGES), .REG_W(REG_W), .T_W(T_W), .K_W(FWD_W)) u_match_rs (
    .recs (rec_q),
    .r    (hz.d_rs),
    .hit  (rs_hit),
    .k    (rs_k),
    .tnew (rs_tnew)
  );

  hazard_match #(.STAGES(STAGES), .REG_W(REG_W), .T_W(T_W), .K_W(FWD_W)) u_match_rt (
    .recs (rec_q),
    .r    (hz.d_rt),
    .hit  (rt_hit),
    .k    (rt_k),
    .tnew (rt_tnew)
  );

  always_comb begin
    rs_stall = rs_hit && (hz.d_rs_tuse != TUSE_NONE) && (rs_tnew > hz.d_rs_tuse);
    rt_stall = rt_hit && (hz.d_rt_tuse != TUSE_NONE) && (rt_tnew > hz.d_rt_tuse);
    md_stall = hz.d_md_use && (cnt_q != '0);
    stall_c  = hz.d_valid && (rs_stall || rt_stall || md_stall);

    hz.stall   = stall_c;
    hz.md_busy = (cnt_q != '0);
    // Only a finished result (tnew 0) forwards; otherwise a later stage will.
    hz.fwd_rs  = (hz.d_valid && rs_hit && (rs_tnew == '0)) ? rs_k : '0;
    hz.fwd_rt  = (hz.d_valid && rt_hit && (rt_tnew == '0)) ? rt_k : '0;
  end

  // A stalled decode slot enters E as an invalid record (bubble).
  always_comb begin
    rec_d[STG_E] = '{valid: hz.d_valid & ~stall_c, dst: hz.d_dst, tnew: hz.d_tnew};
    for (int i = STG_E + 1; i <= STAGES; i++) begin
      rec_d[i] = '{valid: rec_q[i-1].valid, dst: rec_q[i-1].dst,
                   tnew: tnew_dec(rec_q[i-1].tnew)};
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (hz.d_valid && hz.d_md_start && !stall_c) begin
      cnt_d = hz.d_md_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 1; i <= STAGES; i++) begin
        rec_q[i] <= '0;
      end
      cnt_q <= '0;
    end else begin
      rec_q <= rec_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed-vector bench for hazard_unit with hand-computed expected outputs.
module tb_hazard_unit;

  localparam logic [1:0] N = 2'b11;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  hazard_unit_if #(.REG_W(5), .T_W(2), .FWD_W(2)) hz ();

  hazard_unit #(.REG_W(5), .STAGES(3), .T_W(2), .MUL_LAT(5), .DIV_LAT(10)) dut (
    .clk   (clk),
    .reset (reset),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v,
                       input logic [4:0] rs, input logic [1:0] rs_t,
                       input logic [4:0] rt, input logic [1:0] rt_t,
                       input logic [4:0] dst, input logic [1:0] tn,
                       input logic ms, input logic md, input logic mu);
    hz.d_valid    = v;
    hz.d_rs       = rs;
    hz.d_rs_tuse  = rs_t;
    hz.d_rt       = rt;
    hz.d_rt_tuse  = rt_t;
    hz.d_dst      = dst;
    hz.d_tnew     = tn;
    hz.d_md_start = ms;
    hz.d_md_div   = md;
    hz.d_md_use   = mu;
  endtask

  task automatic drive_random();
    hz.d_valid    = 1'($urandom);
    hz.d_rs       = 5'($urandom);
    hz.d_rs_tuse  = 2'($urandom);
    hz.d_rt       = 5'($urandom);
    hz.d_rt_tuse  = 2'($urandom);
    hz.d_dst      = 5'($urandom);
    hz.d_tnew     = 2'($urandom);
    hz.d_md_start = 1'($urandom);
    hz.d_md_div   = 1'($urandom);
    hz.d_md_use   = 1'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic e_stall, input logic [1:0] e_rs,
                       input logic [1:0] e_rt, input logic e_busy);
    #1;
    vectors++;
    assert ({hz.stall, hz.fwd_rs, hz.fwd_rt, hz.md_busy} === {e_stall, e_rs, e_rt, e_busy})
    else begin
      miscompares++;
      $error("FAIL %s: got stall=%b fwd_rs=%0d fwd_rt=%0d busy=%b, want stall=%b fwd_rs=%0d fwd_rt=%0d busy=%b",
             tag, hz.stall, hz.fwd_rs, hz.fwd_rt, hz.md_busy, e_stall, e_rs, e_rt, e_busy);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    drive(0, 0, N, 0, N, 0, 0, 0, 0, 0);

    // Reset held with random decode inputs: nothing in flight, so all outputs 0.
    for (int i = 0; i < 2; i++) begin
      drive_random();
      tick();
      check("reset", 0, 0, 0, 0);
    end

    reset = 1'b1;
    drive(1, 8, 1, 0, N, 0, 0, 0, 0, 0);
    check("release", 0, 0, 0, 0);
    tick();

    // Load-use: lw $8 (tnew 2) then addu $9,$8,$8 (tuse 1).
    drive(1, 29, 1, 0, N, 8, 2, 0, 0, 0);
    check("lw_issue", 0, 0, 0, 0);
    tick();
    drive(1, 8, 1, 8, 1, 9, 1, 0, 0, 0);
    check("loaduse_stall", 1, 0, 0, 0);
    tick();
    check("loaduse_go", 0, 0, 0, 0);
    tick();
    // $8 now in W with tnew 0, $9 in E with tnew 1 == tuse.
    drive(1, 8, 1, 9, 1, 10, 1, 0, 0, 0);
    check("fwd_from_w", 0, 3, 0, 0);
    tick();

    // Branch after ALU op.
    drive(1, 0, 1, 0, N, 8, 1, 0, 0, 0);
    check("addiu_issue", 0, 0, 0, 0);
    tick();
    drive(1, 8, 0, 0, 0, 0, 0, 0, 0, 0);
    check("branch_stall", 1, 0, 0, 0);
    tick();
    check("branch_fwd_m", 0, 2, 0, 0);
    tick();

    // Nearest wins: $8 in E (tnew 1) and M (tnew 0).
    drive(1, 0, N, 0, N, 8, 1, 0, 0, 0);
    check("near_a", 0, 0, 0, 0);
    tick();
    drive(1, 0, N, 0, N, 8, 1, 0, 0, 0);
    check("near_b", 0, 0, 0, 0);
    tick();
    drive(1, 8, 1, 8, N, 0, 0, 0, 0, 0);
    check("nearest_tuse1", 0, 0, 0, 0);
    drive(1, 8, 0, 0, N, 0, 0, 0, 0, 0);
    check("nearest_tuse0", 1, 0, 0, 0);
    drive(0, 8, 1, 8, 1, 0, 0, 0, 0, 0);
    check("bubble_no_fwd", 0, 0, 0, 0);
    tick();

    // $0 never matches; Tuse none never stalls.
    drive(1, 0, N, 0, N, 8, 2, 0, 0, 0);
    check("lw8_issue", 0, 0, 0, 0);
    tick();
    drive(1, 0, 0, 8, N, 0, 0, 0, 0, 0);
    check("tuse_none", 0, 0, 0, 0);
    tick();
    check("reg0_no_fwd", 0, 0, 0, 0);
    tick();

    // Divide: busy for exactly 10 cycles; mflo stalls throughout.
    drive(1, 0, N, 0, N, 0, 0, 1, 1, 1);
    check("div_issue", 0, 0, 0, 0);
    tick();
    drive(1, 0, N, 0, N, 9, 1, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("mflo_wait%0d", i), 1, 0, 0, 1);
      tick();
    end
    check("mflo_go", 0, 0, 0, 0);
    tick();

    // Multiply: busy for exactly 5 cycles.
    drive(1, 0, N, 0, N, 0, 0, 1, 0, 1);
    check("mult_issue", 0, 0, 0, 0);
    tick();
    drive(0, 0, N, 0, N, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("mult_busy%0d", i), 0, 0, 0, 1);
      tick();
    end
    check("mult_done", 0, 0, 0, 0);

    // Reset mid-operation clears records and counter.
    drive(1, 0, N, 0, N, 0, 0, 1, 1, 1);
    tick();
    drive(1, 0, N, 0, N, 8, 2, 0, 0, 0);
    check("pre_rst_busy", 0, 0, 0, 1);
    tick();
    drive(1, 8, 1, 0, N, 9, 1, 0, 0, 1);
    check("pre_rst_stall", 1, 0, 0, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("post_rst", 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
